rv_ready_gen: RTL

RV_READY_GEN -- requirements
Module: rv_ready_gen

---
 rtl/rv_ready_gen_if.sv | 26 ++
 rtl/rv_ready_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rv_ready_gen_if.sv
// rtl/rv_ready_gen_if.sv - producer/consumer valid-ready handshake bundle
// Purpose: carries one data beat per cycle with data_valid && data_ready.
// Ports (signals):
//   data       producer data, DATA_W bits
//   data_valid producer has a beat on data
//   data_ready consumer can accept a beat this cycle
// Modports: master = producer side, slave = consumer side (rv_ready_gen).
interface rv_ready_gen_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/rv_ready_gen.sv
// rtl/rv_ready_gen.sv - configurable backpressure generator with beat statistics
// Purpose: consumer model that delays data_ready by a fixed or LFSR-random
// number of cycles, counts/accumulates accepted beats and flags producers
// that withdraw or change a stalled beat.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   bus            slave side of rv_ready_gen_if (data, data_valid, data_ready)
//   mode           0 always ready, 1 fixed delay, 2 random delay, 3 pause
//   cfg_delay      fixed delay (mode 1) or random mask (mode 2)
//   clr            synchronous clear of statistics and proto_err
//   beat_count     accepted beats, wraps at 2^32
//   checksum       XOR of accepted data
//   last_data      most recently accepted data
//   proto_err      sticky producer protocol violation
module rv_ready_gen #(
  parameter int          DATA_W  = 32,
  parameter int          DELAY_W = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  rv_ready_gen_if.slave      bus,
  input  logic [1:0]         mode,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic               clr,
  output logic [31:0]        beat_count,
  output logic [DATA_W-1:0]  checksum,
  output logic [DATA_W-1:0]  last_data,
  output logic               proto_err
);

  // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [1:0] MODE_PAUSE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t              state_q;
  logic [DELAY_W-1:0]  cnt_q;
  logic [15:0]         lfsr_q;
  logic [15:0]         lfsr_d;
  logic [DELAY_W-1:0]  delay_sel;
  logic                ready;
  logic                beat;

  logic [31:0]         beat_count_q, beat_count_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic [DATA_W-1:0]   last_data_q, last_data_d;
  logic                proto_err_q, proto_err_d;
  logic                stall_q;
  logic [DATA_W-1:0]   prev_data_q;

  // Ready is decoded combinationally so that it drops in the very cycle
  // reset or pause is applied.
  always_comb begin
    ready = 1'b0;
    if (!reset) begin
      if (mode == MODE_ALWAYS)
        ready = 1'b1;
      else if (mode != MODE_PAUSE)
        ready = (state_q == ST_READY);
    end
  end

  assign bus.data_ready = ready;
  assign beat           = bus.data_valid && ready;

  assign delay_sel = (mode == MODE_RANDOM) ? (lfsr_q[DELAY_W-1:0] & cfg_delay)
                                           : cfg_delay;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0])
      lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clock) begin
    if (reset)
      lfsr_q <= SEED_EFF;
    else
      lfsr_q <= lfsr_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (mode)
        MODE_ALWAYS: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        MODE_PAUSE: ;  // state and count frozen, resumed on exit
        default: begin
          case (state_q)
            ST_IDLE: begin
              if (bus.data_valid) begin
                cnt_q   <= delay_sel;
                state_q <= ST_WAIT;
              end
            end
            ST_WAIT: begin
              if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
              else
                state_q <= ST_READY;
            end
            ST_READY: begin
              if (beat)
                state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      endcase
    end
  end

  // clr restarts statistics from zero, so a coincident beat is the first one.
  always_comb begin
    beat_count_d = beat_count_q;
    checksum_d   = checksum_q;
    last_data_d  = last_data_q;
    proto_err_d  = proto_err_q;
    if (clr) begin
      beat_count_d = '0;
      checksum_d   = '0;
      last_data_d  = '0;
      proto_err_d  = 1'b0;
    end
    if (beat) begin
      beat_count_d = beat_count_d + 32'd1;
      checksum_d   = checksum_d ^ bus.data;
      last_data_d  = bus.data;
    end
    // A stalled beat must be held unchanged until it is accepted.
    if (!clr && stall_q && (!bus.data_valid || bus.data != prev_data_q))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_count_q <= '0;
      checksum_q   <= '0;
      last_data_q  <= '0;
      proto_err_q  <= 1'b0;
      stall_q      <= 1'b0;
      prev_data_q  <= '0;
    end else begin
      beat_count_q <= beat_count_d;
      checksum_q   <= checksum_d;
      last_data_q  <= last_data_d;
      proto_err_q  <= proto_err_d;
      stall_q      <= bus.data_valid && !ready;
      prev_data_q  <= bus.data;
    end
  end

  assign beat_count = beat_count_q;
  assign checksum   = checksum_q;
  assign last_data  = last_data_q;
  assign proto_err  = proto_err_q;

endmodule
